bus_arbiter: RTL

//   Two-master bus arbiter and master-side mux. Sits directly upstream of the

---
 rtl/bus_arbiter.sv | 137 +++++++++++++
 1 files changed

// File: rtl/bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : bus_arbiter
//  Description : Two-master bus arbiter and master-side mux. Grants the shared
//                bus round-robin on contention and bounds how long one master
//                may keep the bus while the other is waiting.
//  Ports       : clk, reset_n (async, active-low)
//                m0_req/m0_wr/m0_addr/m0_dout  - master 0 request side
//                m1_req/m1_wr/m1_addr/m1_dout  - master 1 request side
//                m0_grant/m1_grant             - registered, one-hot or zero
//                bus_valid/bus_wr/bus_addr/bus_wdata - muxed bus to decoder
//  Revision    : 1.0  initial release
// ============================================================================
module bus_arbiter #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 32,
    parameter int MAX_HOLD = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              m0_req,
    input  logic              m0_wr,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_dout,
    input  logic              m1_req,
    input  logic              m1_wr,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_dout,
    output logic              m0_grant,
    output logic              m1_grant,
    output logic              bus_valid,
    output logic              bus_wr,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata
);

    // A zero-width counter is not legal, so MAX_HOLD=0 still gets one bit;
    // the counter simply never moves in that configuration.
    localparam int HOLD_W     = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam int HOLD_LIM_I = (MAX_HOLD > 0) ? (MAX_HOLD - 1) : 0;
    localparam logic [HOLD_W-1:0] HOLD_LIM   = HOLD_W'(HOLD_LIM_I);
    localparam bit                PREEMPT_EN = (MAX_HOLD != 0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GNT_M0 = 2'd1,
        GNT_M1 = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic              last_owner, last_owner_nxt;   // 0 = M0, 1 = M1
    logic [HOLD_W-1:0] hold_cnt, hold_cnt_nxt;
    logic              own_req, other_req, hold_expired;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            last_owner <= 1'b1;   // M1 "last" so M0 wins the first tie
            hold_cnt   <= '0;
        end else begin
            state      <= state_nxt;
            last_owner <= last_owner_nxt;
            hold_cnt   <= hold_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        last_owner_nxt = last_owner;
        hold_cnt_nxt   = '0;
        own_req        = (state == GNT_M1) ? m1_req : m0_req;
        other_req      = (state == GNT_M1) ? m0_req : m1_req;
        hold_expired   = PREEMPT_EN && (hold_cnt == HOLD_LIM);

        case (state)
            IDLE: begin
                if (m0_req && m1_req)
                    state_nxt = last_owner ? GNT_M0 : GNT_M1;
                else if (m0_req)
                    state_nxt = GNT_M0;
                else if (m1_req)
                    state_nxt = GNT_M1;
            end
            GNT_M0: begin
                if (!own_req)
                    state_nxt = other_req ? GNT_M1 : IDLE;
                else if (other_req && hold_expired)
                    state_nxt = GNT_M1;
            end
            GNT_M1: begin
                if (!own_req)
                    state_nxt = other_req ? GNT_M0 : IDLE;
                else if (other_req && hold_expired)
                    state_nxt = GNT_M0;
            end
            default: state_nxt = IDLE;
        endcase

        // Only an actual entry into a grant state moves the round-robin pointer.
        if (state_nxt != state) begin
            if (state_nxt == GNT_M0)
                last_owner_nxt = 1'b0;
            else if (state_nxt == GNT_M1)
                last_owner_nxt = 1'b1;
        end

        // Counts contested cycles of the current owner; saturates at the limit.
        if (state_nxt == state && state != IDLE && other_req) begin
            if (hold_cnt != HOLD_LIM)
                hold_cnt_nxt = hold_cnt + HOLD_W'(1);
            else
                hold_cnt_nxt = hold_cnt;
        end
    end

    assign m0_grant  = (state == GNT_M0);
    assign m1_grant  = (state == GNT_M1);
    assign bus_valid = m0_grant | m1_grant;

    // IDLE drives zeros; slaves must qualify with bus_valid.
    always_comb begin
        bus_wr    = 1'b0;
        bus_addr  = '0;
        bus_wdata = '0;
        if (state == GNT_M0) begin
            bus_wr    = m0_wr;
            bus_addr  = m0_addr;
            bus_wdata = m0_dout;
        end else if (state == GNT_M1) begin
            bus_wr    = m1_wr;
            bus_addr  = m1_addr;
            bus_wdata = m1_dout;
        end
    end

endmodule
`default_nettype wire
